// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types, default widths and counter sizing for the memory arbiter
// No ports; imported by mem_arbiter and mem_arb_wdog.
package mem_arb_pkg;
   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_TIMEOUT = 16;
   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, RESP} arb_state_e;
   typedef enum logic {GNT_IF, GNT_DM} gnt_e;
   function automatic int cnt_w(int t);
      return $clog2(t);
   endfunction
endpackage

// File: rtl/mem_arb_wdog.sv
// mem_arb_wdog: wait-cycle counter that flags a memory access stuck for TIMEOUT cycles
// Ports:
//   clk     in  clock, rising edge
//   rst_n   in  asynchronous active-low reset
//   clr     in  restart count at 0 (new access granted)
//   en      in  count one more waiting cycle
//   expired out count has reached TIMEOUT-1
module mem_arb_wdog
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int CW = cnt_w(TIMEOUT);
   logic [CW-1:0] cnt;
   assign expired = cnt == CW'(TIMEOUT - 1);
   // Saturates at the expiry value so a stale count can never wrap back to a live one.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the IF (read) and DM (read/write) ports
// Build option: define MEM_ARB_RR_EN to alternate grants when both ports request together;
// otherwise DM always wins a simultaneous request.
// Ports:
//   clk_i, rst_i            clock (rising edge), asynchronous active-low reset
//   if_req_i/if_addr_i      IF read request and address
//   if_rdata_o/if_done_o    IF read data (held) and one-cycle completion pulse
//   if_stall_o              IF request outstanding
//   dm_req_i/we/addr/wdata  DM request, write enable, address and write data
//   dm_rdata_o/dm_done_o    DM read data (reads only) and one-cycle completion pulse
//   dm_stall_o              DM request outstanding
//   err_o                   pulses with the done of an access that timed out
//   mem_req/we/addr/wdata_o registered memory request
//   mem_rdata_i/mem_ready_i memory read data and transfer-complete strobe
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_done_o,
   output logic              if_stall_o,
   input  logic              dm_req_i,
   input  logic              dm_we_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_wdata_i,
   output logic [DATA_W-1:0] dm_rdata_o,
   output logic              dm_done_o,
   output logic              dm_stall_o,
   output logic              err_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ready_i
);
   arb_state_e state, state_nx;
   gnt_e       cur;
   logic       err, busy, finish, expired, if_elig, dm_elig, grant, pick_dm;

   // cur remembers which port owns the access in flight; it is also the last grant.
   assign if_done_o  = state == RESP && cur == GNT_IF;
   assign dm_done_o  = state == RESP && cur == GNT_DM;
   assign err_o      = state == RESP && err;
   assign if_stall_o = if_req_i && !if_done_o;
   assign dm_stall_o = dm_req_i && !dm_done_o;
   assign if_elig    = if_req_i && !if_done_o;
   assign dm_elig    = dm_req_i && !dm_done_o;
   assign busy       = state == BUSY_IF || state == BUSY_DM;
   // A ready in the last allowed cycle still completes normally.
   assign finish     = busy && (mem_ready_i || expired);
   assign grant      = state == IDLE && (if_elig || dm_elig);
`ifdef MEM_ARB_RR_EN
   assign pick_dm    = dm_elig && (!if_elig || cur == GNT_IF);
`else
   assign pick_dm    = dm_elig;
`endif

   mem_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk     (clk_i),
      .rst_n   (rst_i),
      .clr     (grant),
      .en      (busy && !mem_ready_i),
      .expired (expired)
   );

   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (grant) state_nx = pick_dm ? BUSY_DM : BUSY_IF;
         BUSY_IF,
         BUSY_DM: if (finish) state_nx = RESP;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         if_rdata_o  <= '0;
         dm_rdata_o  <= '0;
         err         <= 1'b0;
         cur         <= GNT_IF;
      end else begin
         if (grant) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= pick_dm && dm_we_i;
            mem_addr_o  <= pick_dm ? dm_addr_i : if_addr_i;
            mem_wdata_o <= pick_dm ? dm_wdata_i : '0;
            cur         <= pick_dm ? GNT_DM : GNT_IF;
            err         <= 1'b0;
         end
         if (finish) begin
            mem_req_o <= 1'b0;
            err       <= !mem_ready_i;
         end
         if (state == BUSY_IF && mem_ready_i) if_rdata_o <= mem_rdata_i;
         if (state == BUSY_DM && mem_ready_i && !mem_we_o) dm_rdata_o <= mem_rdata_i;
      end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized bench for mem_arbiter against a transaction-level timing model
module tb_mem_arbiter;
   localparam int TO = 6;
`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0, rst_i = 1'b0;
   logic        if_req_i = 1'b0, dm_req_i = 1'b0, dm_we_i = 1'b0, mem_ready_i = 1'b0;
   logic [31:0] if_addr_i = '0, dm_addr_i = '0, dm_wdata_i = '0, mem_rdata_i = '0;
   logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
   logic        if_done_o, if_stall_o, dm_done_o, dm_stall_o, err_o, mem_req_o, mem_we_o;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
      .if_done_o(if_done_o), .if_stall_o(if_stall_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
      .dm_rdata_o(dm_rdata_o), .dm_done_o(dm_done_o), .dm_stall_o(dm_stall_o),
      .err_o(err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i)
   );

   int n_cmp = 0, n_bad = 0;
   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Requesters: port 0 = IF, port 1 = DM.
   bit          pend[2], drop[2], r_we[2];
   logic [31:0] r_addr[2], r_wdata[2];
   logic [31:0] mem[64];
   // Model: one access in flight, granted at s, memory answers after lat cycles of request.
   bit          act, fl_err, ex_we, mlast;
   int          fl_p, s, lat, n, free_at, cyc;
   int          done_at[2], obs_done[2], obs_err, upd_p;
   logic [31:0] ex_addr, ex_wdata, upd_v, exp_rd[2];
   int          p_new, drop_pct, force_lat, t0;
   int          order[$];
   int          exp_g[4];

   task automatic issue(int p, logic [31:0] a, bit we, logic [31:0] wd);
      r_addr[p] = a;
      r_we[p] = we;
      r_wdata[p] = wd;
      pend[p] = 1'b1;
   endtask

   task automatic new_req(int p);
      issue(p, {24'b0, 6'($urandom_range(63)), 2'b00}, p == 1 && $urandom_range(1) == 1, $urandom);
   endtask

   task automatic step();
      bit pick, in_busy;
      int idx;
      @(posedge clk);
      #1;
      cyc++;
      if (upd_p >= 0) begin
         exp_rd[upd_p] = upd_v;
         upd_p = -1;
      end
      for (int p = 0; p < 2; p++) begin
         if (pend[p] && done_at[p] == cyc - 1) begin
            pend[p] = 1'b0;
            drop[p] = 1'b0;
         end
         if (!pend[p] && $urandom_range(99) < p_new) new_req(p);
         if (act && fl_p == p && cyc > s && cyc <= s + n && $urandom_range(99) < drop_pct) drop[p] = 1'b1;
      end
      if (cyc >= free_at && (pend[0] || pend[1])) begin
         pick = pend[1] && (!pend[0] || !RR || !mlast);
         mlast = pick;
         fl_p = int'(pick);
         s = cyc;
         act = 1'b1;
         lat = force_lat > 0 ? force_lat : int'($urandom_range(TO + 2, 1));
         n = lat > TO ? TO : lat;
         fl_err = lat > TO;
         done_at[fl_p] = s + n + 1;
         free_at = s + n + 2;
         ex_addr = r_addr[fl_p];
         ex_we = pick && r_we[1];
         ex_wdata = r_wdata[fl_p];
      end
      in_busy = act && cyc > s && cyc <= s + n;
      if (act && !fl_err && cyc == s + lat) begin
         mem_ready_i = 1'b1;
         idx = int'(ex_addr[7:2]);
         if (ex_we) begin
            mem[idx] = ex_wdata;
            mem_rdata_i = $urandom;
         end else begin
            mem_rdata_i = mem[idx];
            upd_p = fl_p;
            upd_v = mem[idx];
         end
      end else begin
         mem_ready_i = !in_busy && $urandom_range(3) == 0;
         mem_rdata_i = $urandom;
      end
      if_req_i = pend[0] && !drop[0];
      if_addr_i = r_addr[0];
      dm_req_i = pend[1] && !drop[1];
      dm_we_i = r_we[1];
      dm_addr_i = r_addr[1];
      dm_wdata_i = r_wdata[1];
      @(negedge clk);
      check("mem_req", mem_req_o, in_busy);
      if (in_busy) begin
         check("mem_addr", mem_addr_o, ex_addr);
         check("mem_we", mem_we_o, ex_we);
         if (ex_we) check("mem_wdata", mem_wdata_o, ex_wdata);
      end
      check("if_done", if_done_o, done_at[0] == cyc);
      check("dm_done", dm_done_o, done_at[1] == cyc);
      check("err", err_o, act && fl_err && cyc == s + n + 1);
      check("if_stall", if_stall_o, pend[0] && !drop[0] && done_at[0] != cyc);
      check("dm_stall", dm_stall_o, pend[1] && !drop[1] && done_at[1] != cyc);
      check("if_rdata", if_rdata_o, exp_rd[0]);
      check("dm_rdata", dm_rdata_o, exp_rd[1]);
      if (if_done_o) begin obs_done[0] = cyc; order.push_back(0); end
      if (dm_done_o) begin obs_done[1] = cyc; order.push_back(1); end
      if (err_o) obs_err = cyc;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && (pend[0] || pend[1] || cyc < free_at); i++) step();
      check("drain", {30'b0, pend[1], pend[0]}, 32'd0);
   endtask

   task automatic model_reset();
      if_req_i = 1'b0;
      dm_req_i = 1'b0;
      mem_ready_i = 1'b0;
      for (int p = 0; p < 2; p++) begin
         pend[p] = 1'b0;
         drop[p] = 1'b0;
         done_at[p] = -100;
         exp_rd[p] = '0;
      end
      act = 1'b0;
      mlast = 1'b0;
      upd_p = -1;
      free_at = 0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      for (int i = 0; i < 4; i++) exp_g[i] = RR ? int'(i % 2 == 0) : 1;
      cyc = 0; p_new = 0; drop_pct = 0; force_lat = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      check("rst_mem_req", mem_req_o, 0);
      check("rst_mem_we", mem_we_o, 0);
      check("rst_mem_addr", mem_addr_o, 0);
      check("rst_mem_wdata", mem_wdata_o, 0);
      check("rst_if_rdata", if_rdata_o, 0);
      check("rst_dm_rdata", dm_rdata_o, 0);
      check("rst_dones", {30'b0, if_done_o, dm_done_o}, 0);
      check("rst_err", err_o, 0);
      rst_i = 1'b1;

      // Single IF read, ready one cycle after the request.
      mem[16] = 32'h8C010004;
      force_lat = 2; obs_done = '{-1, -1};
      issue(0, 32'h40, 1'b0, 32'h0);
      t0 = cyc + 1;
      repeat (6) step();
      check("t1_latency", obs_done[0] - t0, 3);
      check("t1_rdata", if_rdata_o, 32'h8C010004);

      // Simultaneous IF read and DM write: DM goes first.
      obs_done = '{-1, -1};
      issue(1, 32'h10, 1'b1, 32'hDEAD);
      issue(0, 32'h20, 1'b0, 32'h0);
      t0 = cyc + 1;
      repeat (12) step();
      check("t2_dm_latency", obs_done[1] - t0, 3);
      check("t2_if_after_dm", obs_done[0] - obs_done[1], 4);

      // Both ports requesting continuously.
      order.delete();
      force_lat = 1; p_new = 100;
      repeat (14) step();
      p_new = 0;
      drain();
      for (int i = 0; i < 4; i++) check("t3_grant_order", i < order.size() ? order[i] : 2, exp_g[i]);

      // Memory never answers: abort after TO request cycles.
      obs_done = '{-1, -1}; obs_err = -1;
      force_lat = TO + 2;
      issue(0, 32'h08, 1'b0, 32'h0);
      t0 = cyc + 1;
      repeat (TO + 4) step();
      check("t4_done_latency", obs_done[0] - t0, TO + 1);
      check("t4_err_latency", obs_err - t0, TO + 1);

      // DM read answered in the last allowed cycle.
      mem[9] = 32'h1234;
      obs_done = '{-1, -1};
      force_lat = 6;
      issue(1, 32'h24, 1'b0, 32'h0);
      t0 = cyc + 1;
      repeat (10) step();
      check("t6_latency", obs_done[1] - t0, 7);
      check("t6_rdata", dm_rdata_o, 32'h1234);

      // Random traffic with random latencies, timeouts and illegal early drops.
      force_lat = 0; p_new = 30; drop_pct = 2;
      repeat (3000) step();
      p_new = 0; drop_pct = 0;
      drain();

      // Reset during a DM access.
      force_lat = TO + 2;
      issue(1, 32'h80, 1'b0, 32'h0);
      repeat (3) step();
      #2;
      rst_i = 1'b0;
      model_reset();
      #1;
      check("rst_mid_mem_req", mem_req_o, 0);
      check("rst_mid_dm_done", dm_done_o, 0);
      check("rst_mid_dm_rdata", dm_rdata_o, 0);
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_i = 1'b1;
      obs_done = '{-1, -1};
      force_lat = 3;
      issue(0, 32'h44, 1'b0, 32'h0);
      t0 = cyc + 1;
      repeat (8) step();
      check("t5_if_latency", obs_done[0] - t0, 4);
      check("t5_no_dm_done", obs_done[1], 32'hFFFFFFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
